mul_amisha: RTL and testbench

Sequential shift-and-add multiply-accumulate FSMD that rebuilds a dividend from divider results: prod = quo × dvsr + rmd. It is the inverse counterpart of the team's restoring divider and uses the same start/ready/done_tick handshake, so it can sit directly downstream of the divider for round-trip checking or run standalone as a small multiplier. It processes one multiplier bit per clock.

---
 rtl/mul_amisha_pkg.sv | 13 +
 rtl/mul_amisha.sv | 110 +++++++++++
 tb/tb_mul_amisha.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mul_amisha_pkg.sv
// Shared definitions for the shift-and-add multiply-accumulate unit:
// FSM state encoding and the default operand width.
package mul_amisha_pkg;

    localparam int W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_amisha.sv
// Sequential multiply-accumulate, prod = quo * dvsr + rmd, one multiplier bit per clock.
// Optional MUL_CHK_EN adds err_amisha, flagging inputs that cannot be a valid divider result.
module mul_amisha
    import mul_amisha_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clk_amisha,
    input  logic           reset_amisha,
    input  logic           start_amisha,
    input  logic [W-1:0]   quo_amisha,
    input  logic [W-1:0]   dvsr_amisha,
    input  logic [W-1:0]   rmd_amisha,
    output logic           ready_amisha,
    output logic           done_tick_amisha,
`ifdef MUL_CHK_EN
    output logic           err_amisha,
`endif
    output logic [2*W-1:0] prod_amisha
);

    localparam int NW = $clog2(W) + 1;
    localparam logic [NW-1:0] N_ONE  = NW'(1);
    localparam logic [NW-1:0] N_LOAD = NW'(W);

    state_t          state, state_next;
    logic [W-1:0]    a_reg;
    logic [2*W-1:0]  b_reg;
    logic [2*W-1:0]  p_reg;
    logic [2*W-1:0]  p_sum;
    logic [NW-1:0]   n_reg;
    logic            load;
    logic            step;
    logic            last;

    always_ff @(posedge clk_amisha or negedge reset_amisha) begin
        if (!reset_amisha) state <= IDLE;
        else               state <= state_next;
    end

    always_comb begin
        state_next       = state;
        ready_amisha     = 1'b0;
        done_tick_amisha = 1'b0;
        load             = 1'b0;
        step             = 1'b0;
        case (state)
            IDLE: begin
                ready_amisha = 1'b1;
                if (start_amisha) begin
                    load       = 1'b1;
                    state_next = OP;
                end
            end
            OP: begin
                step = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done_tick_amisha = 1'b1;
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign last  = (n_reg == N_ONE);
    // Worst case (2^W-1)^2 + (2^W-1) still fits in 2W bits, so truncation never loses data.
    assign p_sum = a_reg[0] ? (p_reg + b_reg) : p_reg;

    always_ff @(posedge clk_amisha or negedge reset_amisha) begin
        if (!reset_amisha) begin
            a_reg <= '0;
            b_reg <= '0;
            p_reg <= '0;
            n_reg <= '0;
        end else if (load) begin
            a_reg <= quo_amisha;
            b_reg <= {{W{1'b0}}, dvsr_amisha};
            p_reg <= {{W{1'b0}}, rmd_amisha};
            n_reg <= N_LOAD;
        end else if (step) begin
            a_reg <= a_reg >> 1;
            b_reg <= b_reg << 1;
            p_reg <= p_sum;
            n_reg <= n_reg - N_ONE;
        end
    end

    assign prod_amisha = p_reg;

`ifdef MUL_CHK_EN
    // Operand-side violations are captured at start; the high-half test needs the final sum,
    // so err is written on the last OP edge and is valid alongside done_tick.
    logic chk_reg;

    always_ff @(posedge clk_amisha or negedge reset_amisha) begin
        if (!reset_amisha) begin
            chk_reg    <= 1'b0;
            err_amisha <= 1'b0;
        end else if (load) begin
            chk_reg    <= (rmd_amisha >= dvsr_amisha) || (dvsr_amisha == '0);
            err_amisha <= 1'b0;
        end else if (step && last) begin
            err_amisha <= chk_reg || (p_sum[2*W-1:W] != '0);
        end
    end
`endif

endmodule

// File: tb/tb_mul_amisha.sv
// Directed bench for mul_amisha: latency, results, ignored starts, async abort, optional err flag.
module tb_mul_amisha;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  quo;
    logic [7:0]  dvsr;
    logic [7:0]  rmd;
    logic        ready;
    logic        done;
    logic [15:0] prod;
`ifdef MUL_CHK_EN
    logic        err;
`endif

    int errors = 0;
    int checks = 0;

    mul_amisha #(.W(8)) dut (
        .clk_amisha       (clk),
        .reset_amisha     (rst_n),
        .start_amisha     (start),
        .quo_amisha       (quo),
        .dvsr_amisha      (dvsr),
        .rmd_amisha       (rmd),
        .ready_amisha     (ready),
        .done_tick_amisha (done),
`ifdef MUL_CHK_EN
        .err_amisha       (err),
`endif
        .prod_amisha      (prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one operation; poke > 0 re-pulses start (with quo=9) at that edge index during OP.
    task automatic run_op(input string tag, input logic [7:0] q, input logic [7:0] d,
                          input logic [7:0] r, input logic [15:0] exp_p,
                          input logic exp_e, input int poke);
        int lat;
        int dones;
        lat   = 0;
        dones = 0;
        @(negedge clk);
        quo   = q;
        dvsr  = d;
        rmd   = r;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy"}, 32'(ready), 32'd0);
        check({tag, "_load"}, 32'(prod), 32'(r));
        for (int i = 2; i <= 14; i++) begin
            @(posedge clk);
            #1;
            if (i == poke) begin
                quo   = 8'd9;
                start = 1'b1;
            end else if (i == poke + 1) begin
                start = 1'b0;
            end
            if (done) begin
                dones++;
                if (lat == 0) begin
                    lat = i;
                    check({tag, "_prod"}, 32'(prod), 32'(exp_p));
                    check({tag, "_rdy_in_done"}, 32'(ready), 32'd0);
`ifdef MUL_CHK_EN
                    check({tag, "_err"}, 32'(err), 32'(exp_e));
`endif
                end
            end
            if (lat != 0 && i == lat + 1)
                check({tag, "_rdy_after"}, 32'(ready), 32'd1);
        end
        check({tag, "_latency"}, 32'(lat), 32'd9);
        check({tag, "_done_cnt"}, 32'(dones), 32'd1);
        check({tag, "_hold"}, 32'(prod), 32'(exp_p));
`ifdef MUL_CHK_EN
        check({tag, "_err_hold"}, 32'(err), 32'(exp_e));
`else
        if (exp_e) begin end
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        quo   = '0;
        dvsr  = '0;
        rmd   = '0;
        #12;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_prod", 32'(prod), 32'd0);
`ifdef MUL_CHK_EN
        check("rst_err", 32'(err), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        run_op("t5x7", 8'd5, 8'd7, 8'd0, 16'd35, 1'b0, 0);
        run_op("tmax", 8'd255, 8'd255, 8'd254, 16'd65279, 1'b1, 0);
        run_op("tign", 8'd3, 8'd4, 8'd1, 16'd13, 1'b0, 4);
        run_op("tzero", 8'd0, 8'd0, 8'd0, 16'd0, 1'b1, 0);

        // Abort mid-OP with async reset
        @(negedge clk);
        quo   = 8'd200;
        dvsr  = 8'd100;
        rmd   = 8'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("abort_busy", 32'(ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_prod", 32'(prod), 32'd0);
        check("abort_done", 32'(done), 32'd0);
`ifdef MUL_CHK_EN
        check("abort_err", 32'(err), 32'd0);
`endif
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("abort_nodone", 32'(done), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("abort_idle", 32'(done), 32'd0);
        end

        run_op("t6x6", 8'd6, 8'd6, 8'd2, 16'd38, 1'b0, 0);
        run_op("tchk_bad", 8'd4, 8'd7, 8'd9, 16'd37, 1'b1, 0);
        run_op("tchk_ok", 8'd5, 8'd7, 8'd3, 16'd38, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
